apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles before forced error (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rts_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port m_paddr  input  2*ADDR_WIDTH  master addresses; master i at slice i.
REQ-007 SHALL have port m_pdata  input  2*DATA_WIDTH  master write data; master i at slice i.
REQ-008 SHALL have port m_pwrite  input  2  per-master write flag.
REQ-009 SHALL have port m_pstb  input  8  per-master byte strobes; master i at [4i+3:4i].
REQ-010 SHALL have port m_psel  input  2  per-master transfer request; held until own m_pready.
REQ-011 SHALL have port m_penable  input  2  per-master enable; accepted, not used for timing.
REQ-012 SHALL have port m_prdata  output  DATA_WIDTH  read data, shared by both masters.
REQ-013 SHALL have port m_pready  output  2  per-master completion pulse.
REQ-014 SHALL have port m_perr  output  2  per-master error, valid with m_pready.
REQ-015 SHALL have ports s_paddr/s_pdata/s_pwrite/s_pstb  output  ADDR_WIDTH/DATA_WIDTH/1/4  to APB decoder.
REQ-016 SHALL have ports s_psel, s_penable  output  1 each  APB phase controls.
REQ-017 SHALL have ports s_prdata, s_pready, s_perr  input  DATA_WIDTH/1/1  decoder response.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all s_* and m_* outputs registered.
REQ-019 SHALL, in IDLE with any m_psel high, grant and latch that master's addr/data/pwrite/pstb, enter SETUP next cycle.
REQ-020 SHALL, with both m_psel high in IDLE, grant the master not granted last (round-robin); single requester wins regardless.
REQ-021 SHALL drive s_psel=1, s_penable=0 in SETUP and s_psel=1, s_penable=1 in ACCESS, latched fields stable throughout.
REQ-022 SHALL, in ACCESS with s_pready=1, pulse m_pready[grant] for one cycle, copy s_prdata to m_prdata and s_perr to m_perr[grant], return to IDLE.
REQ-023 SHALL count ACCESS cycles; if count reaches TIMEOUT without s_pready, pulse m_pready[grant] with m_perr[grant]=1, m_prdata=0, return to IDLE.
REQ-024 SHALL keep at least one IDLE cycle between transfers; first request to s_psel latency exactly 1 cycle.
REQ-025 SHALL never assert both m_pready bits, nor m_pready to a non-granted master.
REQ-026 SHALL sample m_psel only in IDLE; m_psel changes during SETUP/ACCESS are ignored.
REQ-027 SHALL update last-grant only on completion (normal or timeout).

Reset
REQ-028 SHALL on rts_n=0 immediately force IDLE, s_psel=s_penable=0, s_paddr/s_pdata/s_pstb/s_pwrite=0, m_pready=m_perr=0, m_prdata=0, counter=0.
REQ-029 SHALL reset last-grant to master 1 so master 0 wins first tie; mid-transfer reset abandons the transfer with no m_pready.

Structure
REQ-030 SHALL place the state enum (IDLE, SETUP, ACCESS) and grant index constants in shared package apb_arb_pkg.
REQ-031 SHALL implement the timeout counter as sub-module apb_watchdog (clear, enable, expired).

Verification
REQ-032 SHALL test: m_psel=01, addr 0x80000010 write 0xDEADBEEF, s_pready on 2nd ACCESS cycle -> s_paddr=0x80000010, s_pdata=0xDEADBEEF, m_pready=01 once.
REQ-033 SHALL test: m_psel=11 held across 4 transfers, s_pready immediate -> grant order 0,1,0,1.
REQ-034 SHALL test: read, s_prdata=0x12345678, s_perr=1 -> m_prdata=0x12345678, m_perr[grant]=1 with m_pready.
REQ-035 SHALL test: TIMEOUT=4, s_pready never -> m_pready and m_perr pulse after 4 ACCESS cycles, s_psel low next cycle.
REQ-036 SHALL test: rts_n low during ACCESS -> s_psel=0 same cycle, no m_pready, next request granted to master 0 on tie.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB arbiter.
// Holds the transfer FSM states, grant indices and the round-robin pick.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    localparam int STRB_W = 4;
    localparam int WDT_W  = 8;

    // On a tie the master that did not complete last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        if (req == 2'b11) begin
            return ~last_grant;
        end
        return req[1] ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase cycle counter; o_expired flags the last allowed ACCESS cycle.
// Cleared whenever the arbiter is outside ACCESS so every transfer starts fresh.
module apb_watchdog
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rts_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WDT_W-1:0] LIMIT = WDT_W'(TIMEOUT - 1);

    logic [WDT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {WDT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count >= LIMIT);

endmodule

// File: rtl/apb_arbiter.sv
// Two-master to one-slave APB arbiter with round-robin grant and ACCESS timeout.
// Every m_* and s_* output comes straight from a register.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rts_n,
    input  logic [2*ADDR_WIDTH-1:0] m_paddr,
    input  logic [2*DATA_WIDTH-1:0] m_pdata,
    input  logic [1:0]              m_pwrite,
    input  logic [2*STRB_W-1:0]     m_pstb,
    input  logic [1:0]              m_psel,
    input  logic [1:0]              m_penable,
    output logic [DATA_WIDTH-1:0]   m_prdata,
    output logic [1:0]              m_pready,
    output logic [1:0]              m_perr,
    output logic [ADDR_WIDTH-1:0]   s_paddr,
    output logic [DATA_WIDTH-1:0]   s_pdata,
    output logic                    s_pwrite,
    output logic [STRB_W-1:0]       s_pstb,
    output logic                    s_psel,
    output logic                    s_penable,
    input  logic [DATA_WIDTH-1:0]   s_prdata,
    input  logic                    s_pready,
    input  logic                    s_perr
);

    arb_state_e r_state;
    arb_state_e w_next_state;

    logic                  r_grant;
    logic                  r_last_grant;
    logic [ADDR_WIDTH-1:0] r_s_paddr;
    logic [DATA_WIDTH-1:0] r_s_pdata;
    logic                  r_s_pwrite;
    logic [STRB_W-1:0]     r_s_pstb;
    logic                  r_s_psel;
    logic                  r_s_penable;
    logic [DATA_WIDTH-1:0] r_m_prdata;
    logic [1:0]            r_m_pready;
    logic [1:0]            r_m_perr;

    logic [1:0]            w_req;
    logic                  w_pick;
    logic                  w_load;
    logic                  w_expired;
    logic                  w_done_ok;
    logic                  w_done_to;
    logic                  w_done;
    logic                  w_s_psel_nxt;
    logic                  w_s_penable_nxt;
    logic [1:0]            w_m_pready_nxt;
    logic [1:0]            w_m_perr_nxt;
    logic [DATA_WIDTH-1:0] w_m_prdata_nxt;
    logic                  w_unused;

    // The master just acknowledged still holds m_psel for that one cycle; mask it out.
    assign w_req     = m_psel & ~r_m_pready;
    assign w_pick    = rr_pick(w_req, r_last_grant);
    assign w_load    = (r_state == IDLE) && (|w_req);
    assign w_done_ok = (r_state == ACCESS) && s_pready;
    assign w_done_to = (r_state == ACCESS) && !s_pready && w_expired;
    assign w_done    = w_done_ok || w_done_to;
    assign w_unused  = ^m_penable;

    apb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rts_n     (rts_n),
        .i_clear   (r_state != ACCESS),
        .i_enable  (r_state == ACCESS),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_next_state = SETUP;
            SETUP:   w_next_state = ACCESS;
            ACCESS:  if (w_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_s_psel_nxt    = (w_next_state != IDLE);
        w_s_penable_nxt = (w_next_state == ACCESS);
        w_m_pready_nxt  = 2'b00;
        w_m_perr_nxt    = 2'b00;
        w_m_prdata_nxt  = r_m_prdata;
        if (w_done) begin
            w_m_pready_nxt[r_grant] = 1'b1;
            w_m_perr_nxt[r_grant]   = w_done_ok ? s_perr : 1'b1;
            w_m_prdata_nxt          = w_done_ok ? s_prdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            r_grant      <= GNT_M0;
            r_last_grant <= GNT_M1;
            r_s_paddr    <= '0;
            r_s_pdata    <= '0;
            r_s_pwrite   <= 1'b0;
            r_s_pstb     <= '0;
            r_s_psel     <= 1'b0;
            r_s_penable  <= 1'b0;
            r_m_prdata   <= '0;
            r_m_pready   <= 2'b00;
            r_m_perr     <= 2'b00;
        end else begin
            r_s_psel    <= w_s_psel_nxt;
            r_s_penable <= w_s_penable_nxt;
            r_m_pready  <= w_m_pready_nxt;
            r_m_perr    <= w_m_perr_nxt;
            r_m_prdata  <= w_m_prdata_nxt;
            if (w_load) begin
                r_grant    <= w_pick;
                r_s_paddr  <= w_pick ? m_paddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_paddr[ADDR_WIDTH-1:0];
                r_s_pdata  <= w_pick ? m_pdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_pdata[DATA_WIDTH-1:0];
                r_s_pwrite <= m_pwrite[w_pick];
                r_s_pstb   <= w_pick ? m_pstb[2*STRB_W-1:STRB_W] : m_pstb[STRB_W-1:0];
            end
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign s_paddr   = r_s_paddr;
    assign s_pdata   = r_s_pdata;
    assign s_pwrite  = r_s_pwrite;
    assign s_pstb    = r_s_pstb;
    assign s_psel    = r_s_psel;
    assign s_penable = r_s_penable;
    assign m_prdata  = r_m_prdata;
    assign m_pready  = r_m_pready;
    assign m_perr    = r_m_perr;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: reset, single write, round-robin, read error,
// timeout and mid-transfer reset, each with hand-computed expectations.
module tb_apb_arbiter;

    logic        clk;
    logic        rts_n;
    logic [63:0] m_paddr;
    logic [63:0] m_pdata;
    logic [1:0]  m_pwrite;
    logic [7:0]  m_pstb;
    logic [1:0]  m_psel;
    logic [1:0]  m_penable;
    logic [31:0] m_prdata;
    logic [1:0]  m_pready;
    logic [1:0]  m_perr;
    logic [31:0] s_paddr;
    logic [31:0] s_pdata;
    logic        s_pwrite;
    logic [3:0]  s_pstb;
    logic        s_psel;
    logic        s_penable;
    logic [31:0] s_prdata;
    logic        s_pready;
    logic        s_perr;

    int n_cmp = 0;
    int n_err = 0;

    apb_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk       (clk),
        .rts_n     (rts_n),
        .m_paddr   (m_paddr),
        .m_pdata   (m_pdata),
        .m_pwrite  (m_pwrite),
        .m_pstb    (m_pstb),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_perr    (m_perr),
        .s_paddr   (s_paddr),
        .s_pdata   (s_pdata),
        .s_pwrite  (s_pwrite),
        .s_pstb    (s_pstb),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_perr    (s_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rts_n = 1'b0;
        tick();
        tick();
        rts_n = 1'b1;
    endtask

    task automatic test_reset();
        m_psel = 2'b00;
        rts_n  = 1'b0;
        tick();
        n_cmp++; if ({s_psel, s_penable} !== 2'b00) begin n_err++; $display("FAIL reset_phase got=%b want=00", {s_psel, s_penable}); end
        n_cmp++; if ({s_paddr, s_pdata} !== 64'h0) begin n_err++; $display("FAIL reset_addr_data got=%h want=0", {s_paddr, s_pdata}); end
        n_cmp++; if ({s_pwrite, s_pstb} !== 5'h0) begin n_err++; $display("FAIL reset_wr_stb got=%b want=00000", {s_pwrite, s_pstb}); end
        n_cmp++; if ({m_pready, m_perr, m_prdata} !== 36'h0) begin n_err++; $display("FAIL reset_master_side got=%h want=0", {m_pready, m_perr, m_prdata}); end
        rts_n = 1'b1;
        tick();
        n_cmp++; if (s_psel !== 1'b0) begin n_err++; $display("FAIL idle_no_req_psel got=%b want=0", s_psel); end
    endtask

    task automatic test_single_write();
        int pulses;
        m_paddr  = {32'h0, 32'h8000_0010};
        m_pdata  = {32'h0, 32'hDEAD_BEEF};
        m_pwrite = 2'b01;
        m_pstb   = 8'h0F;
        s_pready = 1'b0;
        m_psel   = 2'b01;
        tick();
        n_cmp++; if ({s_psel, s_penable} !== 2'b10) begin n_err++; $display("FAIL wr_setup_phase got=%b want=10", {s_psel, s_penable}); end
        n_cmp++; if (s_paddr !== 32'h8000_0010) begin n_err++; $display("FAIL wr_paddr got=%h want=80000010", s_paddr); end
        n_cmp++; if (s_pdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_pdata got=%h want=deadbeef", s_pdata); end
        n_cmp++; if ({s_pwrite, s_pstb} !== 5'h1F) begin n_err++; $display("FAIL wr_pwrite_pstb got=%b want=11111", {s_pwrite, s_pstb}); end
        m_paddr = 64'h0;
        tick();
        n_cmp++; if ({s_psel, s_penable, m_pready} !== 4'b1100) begin n_err++; $display("FAIL wr_access1 got=%b want=1100", {s_psel, s_penable, m_pready}); end
        n_cmp++; if (s_paddr !== 32'h8000_0010) begin n_err++; $display("FAIL wr_paddr_stable got=%h want=80000010", s_paddr); end
        tick();
        n_cmp++; if ({s_psel, s_penable, m_pready} !== 4'b1100) begin n_err++; $display("FAIL wr_access2 got=%b want=1100", {s_psel, s_penable, m_pready}); end
        s_pready = 1'b1;
        tick();
        n_cmp++; if ({m_pready, m_perr, s_psel} !== 5'b01000) begin n_err++; $display("FAIL wr_done got=%b want=01000", {m_pready, m_perr, s_psel}); end
        pulses = (m_pready == 2'b01) ? 1 : 0;
        s_pready = 1'b0;
        m_psel   = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_pready != 2'b00) pulses++;
        end
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL wr_pready_once got=%0d want=1", pulses); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [4];
        logic [1:0] got;
        int         budget;
        exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
        apply_reset();
        m_paddr  = {32'h0000_2000, 32'h0000_1000};
        m_pwrite = 2'b11;
        s_pready = 1'b1;
        s_perr   = 1'b0;
        m_psel   = 2'b11;
        for (int t = 0; t < 4; t++) begin
            budget = 0;
            got    = 2'd3;
            while (!(s_psel && !s_penable) && budget < 10) begin tick(); budget++; end
            if (s_paddr == 32'h0000_1000) got = 2'd0;
            else if (s_paddr == 32'h0000_2000) got = 2'd1;
            n_cmp++; if (got !== exp_order[t]) begin n_err++; $display("FAIL rr_grant_%0d got=%0d want=%0d", t, got, exp_order[t]); end
            budget = 0;
            while (m_pready == 2'b00 && budget < 10) begin tick(); budget++; end
            n_cmp++; if (m_pready !== (2'b01 << exp_order[t])) begin n_err++; $display("FAIL rr_pready_%0d got=%b want=%b", t, m_pready, 2'b01 << exp_order[t]); end
        end
        m_psel   = 2'b00;
        s_pready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_read_error();
        m_paddr  = {32'h0000_3000, 32'h0};
        m_pwrite = 2'b00;
        s_prdata = 32'h1234_5678;
        s_perr   = 1'b1;
        s_pready = 1'b1;
        m_psel   = 2'b10;
        tick();
        n_cmp++; if ({s_psel, s_pwrite, s_paddr} !== {2'b10, 32'h0000_3000}) begin n_err++; $display("FAIL rd_setup got=%b_%h want=10_00003000", {s_psel, s_pwrite}, s_paddr); end
        tick();
        tick();
        n_cmp++; if ({m_pready, m_perr} !== 4'b1010) begin n_err++; $display("FAIL rd_pready_perr got=%b want=1010", {m_pready, m_perr}); end
        n_cmp++; if (m_prdata !== 32'h1234_5678) begin n_err++; $display("FAIL rd_prdata got=%h want=12345678", m_prdata); end
        m_psel   = 2'b00;
        s_pready = 1'b0;
        s_perr   = 1'b0;
        tick();
        n_cmp++; if ({m_pready, m_perr} !== 4'b0000) begin n_err++; $display("FAIL rd_pulse_end got=%b want=0000", {m_pready, m_perr}); end
    endtask

    task automatic test_timeout();
        s_prdata = 32'hCAFE_F00D;
        s_pready = 1'b0;
        m_paddr  = {32'h0, 32'h0000_4000};
        m_psel   = 2'b01;
        tick();
        m_psel = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++; if ({s_psel, s_penable, m_pready} !== 4'b1100) begin n_err++; $display("FAIL to_access_%0d got=%b want=1100", c, {s_psel, s_penable, m_pready}); end
        end
        tick();
        n_cmp++; if ({m_pready, m_perr} !== 4'b0101) begin n_err++; $display("FAIL to_pulse got=%b want=0101", {m_pready, m_perr}); end
        n_cmp++; if (m_prdata !== 32'h0) begin n_err++; $display("FAIL to_prdata got=%h want=0", m_prdata); end
        n_cmp++; if ({s_psel, s_penable} !== 2'b00) begin n_err++; $display("FAIL to_psel_low got=%b want=00", {s_psel, s_penable}); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        pulses   = 0;
        m_paddr  = {32'h0000_2000, 32'h0000_1000};
        s_pready = 1'b0;
        m_psel   = 2'b11;
        tick();
        n_cmp++; if (s_paddr !== 32'h0000_2000) begin n_err++; $display("FAIL mr_grant_m1 got=%h want=00002000", s_paddr); end
        tick();
        n_cmp++; if ({s_psel, s_penable} !== 2'b11) begin n_err++; $display("FAIL mr_in_access got=%b want=11", {s_psel, s_penable}); end
        #2;
        rts_n = 1'b0;
        #1;
        n_cmp++; if ({s_psel, s_penable, m_pready} !== 4'b0000) begin n_err++; $display("FAIL mr_async_clear got=%b want=0000", {s_psel, s_penable, m_pready}); end
        tick();
        if (m_pready != 2'b00) pulses++;
        rts_n = 1'b1;
        tick();
        if (m_pready != 2'b00) pulses++;
        n_cmp++; if ({s_psel, s_penable, s_paddr} !== {2'b10, 32'h0000_1000}) begin n_err++; $display("FAIL mr_tie_to_m0 got=%b_%h want=10_00001000", {s_psel, s_penable}, s_paddr); end
        m_psel = 2'b00;
        tick();
        if (m_pready != 2'b00) pulses++;
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL mr_no_pready got=%0d want=0", pulses); end
        apply_reset();
    endtask

    initial begin
        rts_n     = 1'b0;
        m_paddr   = 64'h0;
        m_pdata   = 64'h0;
        m_pwrite  = 2'b00;
        m_pstb    = 8'h00;
        m_psel    = 2'b00;
        m_penable = 2'b00;
        s_prdata  = 32'h0;
        s_pready  = 1'b0;
        s_perr    = 1'b0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_error();
        test_timeout();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
